// File: rtl/wave_pkt_tx.sv
// Waveform packetiser: ping-pong sample banks framed with a sync/source/frequency header for the UDP TX core.
// Optional `PKT_SEQ_EN adds a wrapping 8-bit packet sequence byte after the frequency field.
module wave_pkt_tx #(
    parameter int unsigned PKT_LEN = 1024,
    parameter logic [7:0]  SRC_ID  = 8'h01,
    parameter logic [7:0]  SYNC    = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [7:0]  sample_data,
    input  logic [12:0] freq,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    input  logic        tx_req,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic [15:0] ovf_cnt
);

`ifdef PKT_SEQ_EN
    localparam int unsigned HDR_LEN = 5;
`else
    localparam int unsigned HDR_LEN = 4;
`endif
    localparam int unsigned TOTAL = PKT_LEN + HDR_LEN;
    localparam int unsigned AW    = $clog2(2 * PKT_LEN);
    localparam int unsigned IW    = $clog2(PKT_LEN);

    typedef enum logic [1:0] {IDLE, START, SEND} state_t;

    logic [7:0]    mem [2*PKT_LEN];
    logic [1:0]    full;
    logic          wr_bank;
    logic          rd_bank;
    logic [IW-1:0] wr_idx;
    logic [12:0]   freq_hold [2];
    logic [15:0]   rd_idx;
    logic [15:0]   sel_idx;
    logic          req_d;
    logic [7:0]    ram_q;
    state_t        state;
`ifdef PKT_SEQ_EN
    logic [7:0]    seq_num;
`endif

    logic          done_evt;
    logic          wr_en;
    logic          wr_last;
    logic          rd_en;
    logic [1:0]    full_set;
    logic [1:0]    full_clr;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [15:0]   data_idx;
    logic [7:0]    byte_val;

    assign tx_byte_num = 16'(TOTAL);

    always_comb begin
        done_evt = (state == SEND) && tx_done;
        wr_en    = sample_valid && !full[wr_bank];
        wr_last  = (wr_idx == IW'(PKT_LEN - 1));
        rd_en    = (state == SEND) && tx_req;
        full_set = (wr_en && wr_last) ? (2'b01 << wr_bank) : 2'b00;
        full_clr = done_evt ? (2'b01 << rd_bank) : 2'b00;
        wr_addr  = AW'(wr_idx) + (wr_bank ? AW'(PKT_LEN) : '0);
        // Header and past-the-end indices park the RAM address at the bank base.
        data_idx = (rd_idx >= 16'(HDR_LEN) && rd_idx < 16'(TOTAL)) ? (rd_idx - 16'(HDR_LEN)) : '0;
        rd_addr  = AW'(data_idx) + (rd_bank ? AW'(PKT_LEN) : '0);
    end

    always_comb begin
        byte_val = '0;
        if (sel_idx == 16'd0)
            byte_val = SYNC;
        else if (sel_idx == 16'd1)
            byte_val = SRC_ID;
        else if (sel_idx == 16'd2)
            byte_val = {3'b000, freq_hold[rd_bank][12:8]};
        else if (sel_idx == 16'd3)
            byte_val = freq_hold[rd_bank][7:0];
`ifdef PKT_SEQ_EN
        else if (sel_idx == 16'd4)
            byte_val = seq_num;
`endif
        else if (sel_idx < 16'(TOTAL))
            byte_val = ram_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= sample_data;
        if (rd_en)
            ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full         <= '0;
            wr_bank      <= 1'b0;
            wr_idx       <= '0;
            ovf_cnt      <= '0;
            freq_hold[0] <= '0;
            freq_hold[1] <= '0;
        end else begin
            // Fill and release always target different banks, so both apply together.
            full <= (full | full_set) & ~full_clr;
            if (wr_en) begin
                if (wr_last) begin
                    freq_hold[wr_bank] <= freq;
                    wr_bank            <= ~wr_bank;
                    wr_idx             <= '0;
                end else begin
                    wr_idx <= wr_idx + IW'(1);
                end
            end else if (sample_valid && ovf_cnt != 16'hFFFF) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rd_bank     <= 1'b0;
            rd_idx      <= '0;
            sel_idx     <= '0;
            req_d       <= 1'b0;
            tx_start_en <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
`ifdef PKT_SEQ_EN
            seq_num     <= '0;
`endif
        end else begin
            tx_start_en <= 1'b0;
            req_d       <= 1'b0;
            if (req_d)
                tx_data <= byte_val;
            case (state)
                IDLE: begin
                    if (full[rd_bank])
                        state <= START;
                end
                START: begin
                    tx_start_en <= 1'b1;
                    busy        <= 1'b1;
                    rd_idx      <= '0;
                    state       <= SEND;
                end
                SEND: begin
                    if (tx_req) begin
                        sel_idx <= rd_idx;
                        req_d   <= 1'b1;
                        if (rd_idx < 16'(TOTAL))
                            rd_idx <= rd_idx + 16'd1;
                    end
                    if (tx_done) begin
                        rd_bank <= ~rd_bank;
                        busy    <= 1'b0;
                        state   <= IDLE;
`ifdef PKT_SEQ_EN
                        seq_num <= seq_num + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_pkt_tx.sv
// Directed bench for wave_pkt_tx with PKT_LEN=16 and a cycle-stepped UDP core model.
module tb_wave_pkt_tx;

    localparam int P = 16;
`ifdef PKT_SEQ_EN
    localparam int H = 5;
`else
    localparam int H = 4;
`endif
    localparam int TOTAL = P + H;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [7:0]  sample_data;
    logic [12:0] freq;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic [15:0] ovf_cnt;

    int n_vec = 0;
    int n_err = 0;

    // UDP core model state: mode 0 off, 1 serve+done, 2 count starts only,
    // 3 serve 7 bytes then abandon, 4 serve then wait for done_go.
    int         udp_mode = 0;
    int         req_left = 0;
    int         n_start  = 0;
    int         pkt_cnt  = 0;
    bit         serving, cap_pending, udp_wait, done_go, aborted;
    logic [7:0] rx_q [$];

    wave_pkt_tx #(.PKT_LEN(P), .SRC_ID(8'h01), .SYNC(8'h5A)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .freq         (freq),
        .tx_start_en  (tx_start_en),
        .tx_byte_num  (tx_byte_num),
        .tx_req       (tx_req),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .busy         (busy),
        .ovf_cnt      (ovf_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int idx, input logic [12:0] f,
                                            input logic [7:0] s0, input logic [7:0] sq);
        if (idx == 0) return 8'h5A;
        if (idx == 1) return 8'h01;
        if (idx == 2) return {3'b000, f[12:8]};
        if (idx == 3) return f[7:0];
        if (H == 5 && idx == 4) return sq;
        if (idx < TOTAL) return s0 + 8'(idx - H);
        return 8'h00;
    endfunction

    // One clock: inputs settle before the edge, outputs observed 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (cap_pending)
            rx_q.push_back(tx_data);
        cap_pending = tx_req;
        tx_done = 1'b0;
        if (tx_start_en) begin
            n_start++;
            check("byte_num", tx_byte_num, TOTAL);
            if (udp_mode == 1 || udp_mode == 3 || udp_mode == 4) begin
                serving  = 1'b1;
                req_left = (udp_mode == 3) ? 7 : TOTAL + 1;
            end
        end
        tx_req   = 1'b0;
        udp_wait = 1'b0;
        if (serving) begin
            if (req_left > 0) begin
                tx_req = 1'b1;
                req_left--;
            end else if (!cap_pending) begin
                if (udp_mode == 3) begin
                    serving = 1'b0;
                    aborted = 1'b1;
                end else if (udp_mode == 1 || done_go) begin
                    tx_done = 1'b1;
                    serving = 1'b0;
                    done_go = 1'b0;
                    pkt_cnt++;
                end else begin
                    udp_wait = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        tx_req = 1'b0;
        tx_done = 1'b0;
        serving = 1'b0;
        cap_pending = 1'b0;
        done_go = 1'b0;
        aborted = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        pkt_cnt = 0;
        n_start = 0;
        rx_q.delete();
    endtask

    task automatic send(input logic [7:0] s0, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_data  = s0 + 8'(i);
            cyc();
            sample_valid = 1'b0;
            for (int g = 0; g < gap; g++) cyc();
        end
    endtask

    task automatic check_pkt(input string tag, input int off, input logic [12:0] f,
                             input logic [7:0] s0, input logic [7:0] sq);
        for (int i = 0; i <= TOTAL; i++)
            check(tag, (off + i < rx_q.size()) ? rx_q[off + i] : 8'hxx, exp_byte(i, f, s0, sq));
    endtask

    initial begin
        rst = 1'b1;
        sample_valid = 1'b0;
        sample_data = '0;
        freq = '0;
        tx_req = 1'b0;
        tx_done = 1'b0;

        // Reset state
        do_reset();
        check("rst_start", tx_start_en, 0);
        check("rst_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf_cnt, 0);
        check("rst_bytenum", tx_byte_num, TOTAL);

        // Single packet: start latency, header, samples, extra request
        udp_mode = 1;
        freq = 13'd1000;
        send(8'h00, P, 0);
        check("t1_start_k", tx_start_en, 0);
        cyc();
        check("t1_start_k1", tx_start_en, 0);
        cyc();
        check("t1_start_k2", tx_start_en, 1);
        check("t1_busy", busy, 1);
        for (int g = 0; g < 60 && pkt_cnt < 1; g++) cyc();
        check("t1_pkt", pkt_cnt, 1);
        cyc();
        check("t1_busy_end", busy, 0);
        check_pkt("t1_byte", 0, 13'd1000, 8'h00, 8'h00);

        // Streaming: four banks back to back, consecutive samples
        rx_q.delete();
        freq = 13'h0123;
        send(8'h10, 4 * P, 1);
        for (int g = 0; g < 200 && pkt_cnt < 5; g++) cyc();
        check("t2_pkts", pkt_cnt, 5);
        cyc();
        check("t2_busy", busy, 0);
        check("t2_ovf", ovf_cnt, 0);
        for (int p = 0; p < 4; p++)
            check_pkt("t2_byte", p * (TOTAL + 1), 13'h0123, 8'(8'h10 + 16 * p), 8'(1 + p));

        // Stalled UDP core: both banks fill, the third bank's worth is dropped
        udp_mode = 2;
        n_start = 0;
        send(8'h00, 3 * P, 0);
        repeat (4) cyc();
        check("t3_ovf", ovf_cnt, P);
        check("t3_starts", n_start, 1);
        check("t3_busy", busy, 1);

        // Reset during a packet
        do_reset();
        check("t4_rst_ovf", ovf_cnt, 0);
        check("t4_rst_busy", busy, 0);
        udp_mode = 3;
        freq = 13'd1000;
        send(8'h20, P, 0);
        for (int g = 0; g < 40 && !aborted; g++) cyc();
        check("t4_aborted", aborted, 1);
        for (int i = 0; i < 7; i++)
            check("t4_byte", (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_byte(i, 13'd1000, 8'h20, 8'h00));
        rst = 1'b1;
        cyc();
        check("t4_busy", busy, 0);
        check("t4_data", tx_data, 0);
        check("t4_start", tx_start_en, 0);
        rst = 1'b0;
        udp_mode = 2;
        n_start = 0;
        repeat (20) cyc();
        check("t4_no_start", n_start, 0);
        send(8'h30, P, 0);
        repeat (4) cyc();
        check("t4_fresh_start", n_start, 1);

        // tx_done coincides with the last fill write of the other bank
        do_reset();
        udp_mode = 4;
        freq = 13'h0AAA;
        send(8'h40, P, 0);
        freq = 13'h1555;
        send(8'h80, P - 1, 0);
        for (int g = 0; g < 60 && !udp_wait; g++) cyc();
        check("t5_wait0", udp_wait, 1);
        check_pkt("t5_pkt0", 0, 13'h0AAA, 8'h40, 8'h00);
        rx_q.delete();
        done_go = 1'b1;
        cyc();
        sample_valid = 1'b1;
        sample_data = 8'h8F;
        cyc();
        sample_valid = 1'b0;
        check("t5_start_d", tx_start_en, 0);
        cyc();
        check("t5_start_d1", tx_start_en, 0);
        cyc();
        check("t5_start_d2", tx_start_en, 1);
        for (int g = 0; g < 60 && !udp_wait; g++) cyc();
        check("t5_wait1", udp_wait, 1);
        check_pkt("t5_pkt1", 0, 13'h1555, 8'h80, 8'h01);

`ifdef PKT_SEQ_EN
        // Sequence byte across a wrap
        do_reset();
        udp_mode = 1;
        for (int p = 0; p < 258; p++)
            send(8'(p), P, 1);
        for (int g = 0; g < 200 && pkt_cnt < 258; g++) cyc();
        check("t6_pkts", pkt_cnt, 258);
        for (int p = 0; p < 258; p++)
            check("t6_seq", (p * (TOTAL + 1) + 4 < rx_q.size()) ? rx_q[p * (TOTAL + 1) + 4] : 8'hxx, 8'(p));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
